// File: rtl/led_matrix_pkg.sv
// Shared types and width helpers for the row-multiplexed LED matrix scanner.
package led_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_matrix_scanner_timer.sv
// Per-row slot timer: BLANK_CYC all-off cycles followed by DWELL_CYC drive cycles.
// Latency: outputs describe the current cycle, decoded straight from the counter flops.
// Backpressure: none; clear parks the timer at the first cycle of a slot.
module scan_slot_timer
    import led_matrix_pkg::*;
#(
    parameter int BLANK_CYC = 0,
    parameter int DWELL_CYC = 1,
    parameter int DW        = width_of(DWELL_CYC + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          in_blank,
    output logic [DW-1:0] d,
    output logic          blank_done,
    output logic          slot_done
);

    localparam int   CW          = width_of((BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC);
    localparam logic START_BLANK = (BLANK_CYC > 0);

    logic          blank_q, blank_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        in_blank   = blank_q;
        blank_done = blank_q && (int'(cnt_q) == BLANK_CYC - 1);
        slot_done  = !blank_q && (int'(cnt_q) == DWELL_CYC - 1);
        d          = blank_q ? '0 : DW'(cnt_q);

        blank_d = blank_q;
        cnt_d   = cnt_q + 1'b1;
        if (clear || slot_done) begin
            blank_d = START_BLANK;
            cnt_d   = '0;
        end else if (blank_done) begin
            blank_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= START_BLANK;
            cnt_q   <= '0;
        end else begin
            blank_q <= blank_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with per-frame PWM brightness and tear-free frame latching.
// Latency: outputs registered one cycle behind the scan state; en=0 blanks them on the next edge.
// Backpressure: none; pixels/brightness are sampled only when a frame starts.
module led_matrix_scanner
    import led_matrix_pkg::scan_state_t, led_matrix_pkg::width_of;
#(
    parameter int   ROWS   = 4,
    parameter int   COLS   = 4,
    parameter int   DWELL  = 1,
    parameter int   BLANK  = 0,
    parameter logic ROW_ON = 1'b0,
    parameter logic COL_ON = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [ROWS*COLS-1:0]            pixels,
    input  logic [width_of(DWELL + 1)-1:0]  brightness,
    output logic [ROWS-1:0]                 row_out,
    output logic [COLS-1:0]                 col_out,
    output logic [width_of(ROWS)-1:0]       row_idx,
    output logic                            frame_start
);

    localparam int RW = width_of(ROWS);
    localparam int BW = width_of(DWELL + 1);

    localparam scan_state_t S_IDLE  = led_matrix_pkg::IDLE;
    localparam scan_state_t S_BLANK = led_matrix_pkg::BLANK;
    localparam scan_state_t S_DRIVE = led_matrix_pkg::DRIVE;
    localparam scan_state_t S_FIRST = (BLANK > 0) ? S_BLANK : S_DRIVE;

    scan_state_t                 state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [ROWS-1:0][COLS-1:0]   buf_q, buf_d;
    logic [BW-1:0]               bright_q, bright_d;
    logic                        first_q, first_d;

    logic [ROWS-1:0]             row_out_q, row_out_d;
    logic [COLS-1:0]             col_out_q, col_out_d;
    logic [RW-1:0]               row_idx_q, row_idx_d;
    logic                        frame_start_q, frame_start_d;

    logic                        scan_clear;
    logic                        in_blank;
    logic [BW-1:0]               dwell_idx;
    logic                        blank_done;
    logic                        slot_done;
    logic                        wrap;
    logic                        new_frame;
    logic [BW-1:0]               bright_sat;

    assign scan_clear = !en || (state_q == S_IDLE);

    scan_slot_timer #(
        .BLANK_CYC (BLANK),
        .DWELL_CYC (DWELL),
        .DW        (BW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (scan_clear),
        .in_blank   (in_blank),
        .d          (dwell_idx),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        wrap       = slot_done && (row_q == RW'(ROWS - 1));
        new_frame  = en && ((state_q == S_IDLE) || wrap);
        bright_sat = (brightness > BW'(DWELL)) ? BW'(DWELL) : brightness;

        state_d  = state_q;
        row_d    = row_q;
        buf_d    = buf_q;
        bright_d = bright_q;
        first_d  = new_frame;

        if (!en) begin
            state_d = S_IDLE;
            row_d   = '0;
        end else if ((state_q == S_IDLE) || slot_done) begin
            state_d = S_FIRST;
            row_d   = ((state_q == S_IDLE) || wrap) ? '0 : row_q + 1'b1;
        end else if (blank_done) begin
            state_d = S_DRIVE;
        end

        if (state_d == S_IDLE) begin
            buf_d    = '0;
            bright_d = '0;
        end else if (new_frame) begin
            buf_d    = pixels;
            bright_d = bright_sat;
        end

        // Output image of the current scan cycle, presented on the next edge.
        row_out_d     = {ROWS{~ROW_ON}};
        col_out_d     = {COLS{~COL_ON}};
        row_idx_d     = '0;
        frame_start_d = 1'b0;
        if (en && (state_q != S_IDLE)) begin
            row_idx_d     = row_q;
            frame_start_d = first_q;
            if (!in_blank) begin
                row_out_d[row_q] = ROW_ON;
                if (dwell_idx < bright_q) begin
                    for (int c = 0; c < COLS; c++) begin
                        col_out_d[c] = buf_q[row_q][c] ? COL_ON : ~COL_ON;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            row_q         <= '0;
            buf_q         <= '0;
            bright_q      <= '0;
            first_q       <= 1'b0;
            row_out_q     <= {ROWS{~ROW_ON}};
            col_out_q     <= {COLS{~COL_ON}};
            row_idx_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            buf_q         <= buf_d;
            bright_q      <= bright_d;
            first_q       <= first_d;
            row_out_q     <= row_out_d;
            col_out_q     <= col_out_d;
            row_idx_q     <= row_idx_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_out     = row_out_q;
    assign col_out     = col_out_q;
    assign row_idx     = row_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: a default 4x4 scanner and a DWELL=4/BLANK=2 variant side by side.
module tb_led_matrix_scanner;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] idx;
        logic       fs;
    } obs_t;

    localparam obs_t INACTIVE = '{row: 4'hF, col: 4'h0, idx: 2'd0, fs: 1'b0};
    localparam int OFF = 0, ARMED = 1, RUN = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [15:0] pix_a, pix_b;
    logic        br_a;
    logic [2:0]  br_b;
    logic [3:0]  row_a, col_a, row_b, col_b;
    logic [1:0]  idx_a, idx_b;
    logic        fs_a, fs_b;

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .ROWS(4), .COLS(4), .DWELL(1), .BLANK(0), .ROW_ON(1'b0), .COL_ON(1'b1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .pixels(pix_a), .brightness(br_a),
        .row_out(row_a), .col_out(col_a), .row_idx(idx_a), .frame_start(fs_a)
    );

    led_matrix_scanner #(
        .ROWS(4), .COLS(4), .DWELL(4), .BLANK(2), .ROW_ON(1'b0), .COL_ON(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .pixels(pix_b), .brightness(br_b),
        .row_out(row_b), .col_out(col_b), .row_idx(idx_b), .frame_start(fs_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    obs_t exp_q[$];

    int dw_cfg [2] = '{1, 4};
    int bl_cfg [2] = '{0, 2};

    // Reference scan position: t counts visible cycles from the first cycle of row 0.
    int          m_state [2];
    int          m_t     [2];
    logic [15:0] m_buf   [2];
    int          m_br    [2];
    logic [15:0] m_pend_pix [2];
    int          m_pend_br  [2];

    function automatic logic in_en(int i);
        return (i == 0) ? en_a : en_b;
    endfunction

    function automatic logic [15:0] in_pix(int i);
        return (i == 0) ? pix_a : pix_b;
    endfunction

    function automatic int in_br(int i);
        return (i == 0) ? int'(br_a) : int'(br_b);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = OFF;
            m_t[i]     = 0;
        end
    endfunction

    function automatic void model_edge(int i);
        int frame;
        frame = 4 * (bl_cfg[i] + dw_cfg[i]);
        if (!in_en(i)) begin
            m_state[i] = OFF;
        end else if (m_state[i] == OFF) begin
            m_state[i]    = ARMED;
            m_pend_pix[i] = in_pix(i);
            m_pend_br[i]  = in_br(i);
        end else begin
            if (m_state[i] == ARMED) begin
                m_state[i] = RUN;
                m_t[i]     = 0;
            end else begin
                m_t[i] = (m_t[i] + 1) % frame;
            end
            if (m_t[i] == 0) begin
                m_buf[i] = m_pend_pix[i];
                m_br[i]  = m_pend_br[i];
            end
            if (m_t[i] == frame - 1) begin
                m_pend_pix[i] = in_pix(i);
                m_pend_br[i]  = in_br(i);
            end
        end
    endfunction

    function automatic obs_t model_out(int i);
        obs_t o;
        int   slot, r, p, lim;
        logic [15:0] fb;
        o = INACTIVE;
        if (m_state[i] == RUN) begin
            slot  = bl_cfg[i] + dw_cfg[i];
            r     = m_t[i] / slot;
            p     = m_t[i] % slot;
            o.idx = 2'(r);
            o.fs  = (m_t[i] == 0);
            if (p >= bl_cfg[i]) begin
                o.row = ~(4'b0001 << r);
                lim   = (m_br[i] > dw_cfg[i]) ? dw_cfg[i] : m_br[i];
                fb    = m_buf[i];
                if ((p - bl_cfg[i]) < lim) o.col = fb[r*4 +: 4];
            end
        end
        return o;
    endfunction

    task automatic check(input int i, input obs_t e, input string tag);
        obs_t obs;
        obs = (i == 0) ? {row_a, col_a, idx_a, fs_a} : {row_b, col_b, idx_b, fs_b};
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed row=%b col=%b idx=%0d fs=%b expected row=%b col=%b idx=%0d fs=%b",
                   tag, obs.row, obs.col, obs.idx, obs.fs, e.row, e.col, e.idx, e.fs);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            obs_t e;
            for (int i = 0; i < 2; i++) begin
                model_edge(i);
                exp_q.push_back(model_out(i));
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                check(i, e, (i == 0) ? "scan_a" : "scan_b");
            end
        end
    endtask

    task automatic wait_pos(input int i, input int t);
        for (int n = 0; n < 200 && !(m_state[i] == RUN && m_t[i] == t); n++) tick(1);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0; en_b = 1'b0;
        pix_a = 16'h0; pix_b = 16'h0;
        br_a  = 1'b0; br_b = 3'd0;
        model_reset();
        #12;
        check(0, INACTIVE, "reset_a");
        check(1, INACTIVE, "reset_b");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain scan on A, 2-lit/2-dark PWM with blank gap on B.
        en_a = 1'b1; pix_a = 16'h0A5F; br_a = 1'b1;
        en_b = 1'b1; pix_b = 16'hFFFF; br_b = 3'd2;
        tick(50);

        // Pixels change mid row 1; old frame must finish untouched.
        wait_pos(1, 8);
        pix_b = 16'h1234;
        wait_pos(0, 1);
        pix_a = 16'hC3A5;
        tick(30);

        // Brightness saturation and zero brightness.
        br_b = 3'd7;
        tick(30);
        br_b = 3'd0; br_a = 1'b0;
        tick(30);
        br_b = 3'd3; br_a = 1'b1;
        tick(30);

        // Drop enable during row 2, then re-enable.
        wait_pos(1, 14);
        en_b = 1'b0;
        tick(3);
        en_b = 1'b1;
        tick(30);
        wait_pos(0, 2);
        en_a = 1'b0;
        tick(2);
        en_a = 1'b1;
        tick(10);

        // Asynchronous reset pulse between edges while B is driving a row.
        wait_pos(1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check(0, INACTIVE, "async_rst_a");
        check(1, INACTIVE, "async_rst_b");
        model_reset();
        #2;
        rst_n = 1'b1;
        pix_a = 16'h8421; pix_b = 16'h5AA5;
        tick(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
